// File: rtl/conv_pkg.sv
// conv_pkg: definitions shared by the convolution kernel array and its lanes.
//   state_e             - job sequencer states
//   sat_e               - saturation classification returned by sat_check
//   acc_width_default() - accumulator width that cannot overflow over a window
//   sat_check()         - classifies a wide signed value against a w-bit signed range
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_HIGH = 2'd1,
        SAT_LOW  = 2'd2
    } sat_e;

    // Width of the scratch value handed to sat_check. Lanes sign-extend
    // their rounded sum to this width, so ACC_WIDTH+1 must not exceed it.
    localparam int SAT_W = 128;
    localparam logic signed [SAT_W-1:0] SAT_ONE = 1;

    // Full-precision products summed over KERNEL_SIZE^2 taps need
    // log2(taps) guard bits above the 2*WIDTH product.
    function automatic int acc_width_default(input int width, input int kernel_size);
        return 2 * width + $clog2(kernel_size * kernel_size);
    endfunction

    // Reports whether v lies above, below or inside [-2^(w-1), 2^(w-1)-1].
    function automatic sat_e sat_check(input logic signed [SAT_W-1:0] v,
                                       input int unsigned w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_ONE <<< (w - 1)) - SAT_ONE;
        lo = -(SAT_ONE <<< (w - 1));
        if (v > hi) begin
            return SAT_HIGH;
        end
        if (v < lo) begin
            return SAT_LOW;
        end
        return SAT_NONE;
    endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// conv_mac_lane: one multiply-accumulate lane of the kernel array.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 clear the accumulator (job start)
//   acc_en              add pixel*weight into the accumulator
//   round_en            register rounded/biased/saturated/ReLU result
//   pixel, weight       signed fixed-point operands (WIDTH bits)
//   bias, relu_en       job-latched bias and ReLU enable
//   result              registered lane result (WIDTH bits)
module conv_mac_lane
    import conv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16,
    parameter int ACC_WIDTH = 68
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    acc_en,
    input  logic                    round_en,
    input  logic signed [WIDTH-1:0] pixel,
    input  logic signed [WIDTH-1:0] weight,
    input  logic signed [WIDTH-1:0] bias,
    input  logic                    relu_en,
    output logic [WIDTH-1:0]        result
);

    localparam int SUM_W = ACC_WIDTH + 1;

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic        [WIDTH-1:0]     res_q, res_d;
    logic signed [2*WIDTH-1:0]   prod;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [SUM_W-1:0]     sum;
    logic        [WIDTH-1:0]     sat_val;

    // Operands widened first so the product keeps all 2*WIDTH bits.
    assign prod = (2*WIDTH)'(pixel) * (2*WIDTH)'(weight);

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + ACC_WIDTH'(prod);
        end

        // Arithmetic shift floors toward -inf; one extra bit keeps the
        // bias addition from wrapping before the saturation check.
        shifted = acc_q >>> FRAC_BITS;
        sum     = SUM_W'(shifted) + SUM_W'(bias);

        case (sat_check(SAT_W'(sum), WIDTH))
            SAT_HIGH: sat_val = {1'b0, {(WIDTH-1){1'b1}}};
            SAT_LOW:  sat_val = {1'b1, {(WIDTH-1){1'b0}}};
            default:  sat_val = sum[WIDTH-1:0];
        endcase
        if (relu_en && sat_val[WIDTH-1]) begin
            sat_val = '0;
        end

        res_d = res_q;
        if (round_en) begin
            res_d = sat_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    assign result = res_q;

endmodule

// File: rtl/conv_kernel_array_acc.sv
// conv_kernel_array_acc: ARRAY_SIZE MAC lanes sharing one broadcast weight.
// Each job accumulates KERNEL_SIZE^2 taps, then bias/saturate/ReLU, then
// presents the lane results on a valid/ready output.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_start, i_bias, i_relu_en  job start (IDLE only) with latched bias/ReLU
//   i_valid / o_ready           tap handshake
//   i_pixel_bus, i_weight       per-lane pixels (lane 0 at MSBs), shared weight
//   o_valid / i_out_ready       result handshake
//   o_pixel_bus                 per-lane results, same lane mapping
//   o_busy                      high whenever not IDLE
module conv_kernel_array_acc
    import conv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int FRAC_BITS   = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int ARRAY_SIZE  = 6,
    parameter int ACC_WIDTH   = acc_width_default(WIDTH, KERNEL_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    input  logic [WIDTH-1:0]            i_bias,
    input  logic                        i_relu_en,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [ARRAY_SIZE*WIDTH-1:0] i_pixel_bus,
    input  logic [WIDTH-1:0]            i_weight,
    output logic                        o_valid,
    input  logic                        i_out_ready,
    output logic [ARRAY_SIZE*WIDTH-1:0] o_pixel_bus,
    output logic                        o_busy
);

    localparam int TAPS  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

    state_e             state_q, state_d;
    logic [TAP_W-1:0]   tap_cnt_q, tap_cnt_d;
    logic [WIDTH-1:0]   bias_q, bias_d;
    logic               relu_q, relu_d;
    logic               clr, acc_en, round_en;

    always_comb begin
        state_d   = state_q;
        tap_cnt_d = tap_cnt_q;
        bias_d    = bias_q;
        relu_d    = relu_q;
        clr       = 1'b0;
        acc_en    = 1'b0;
        round_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    clr       = 1'b1;
                    tap_cnt_d = '0;
                    bias_d    = i_bias;
                    relu_d    = i_relu_en;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                if (i_valid) begin
                    acc_en    = 1'b1;
                    tap_cnt_d = tap_cnt_q + 1'b1;
                    if (tap_cnt_q == LAST_TAP) begin
                        state_d = ROUND;
                    end
                end
            end
            ROUND: begin
                round_en = 1'b1;
                state_d  = OUT;
            end
            OUT: begin
                if (i_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tap_cnt_q <= '0;
            bias_q    <= '0;
            relu_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_cnt_q <= tap_cnt_d;
            bias_q    <= bias_d;
            relu_q    <= relu_d;
        end
    end

    // Handshake outputs decode registered state only.
    assign o_ready = (state_q == ACCUM);
    assign o_valid = (state_q == OUT);
    assign o_busy  = (state_q != IDLE);

    generate
        for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
            conv_mac_lane #(
                .WIDTH     (WIDTH),
                .FRAC_BITS (FRAC_BITS),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr      (clr),
                .acc_en   (acc_en),
                .round_en (round_en),
                .pixel    (i_pixel_bus[(ARRAY_SIZE-gi)*WIDTH-1 -: WIDTH]),
                .weight   (i_weight),
                .bias     (bias_q),
                .relu_en  (relu_q),
                .result   (o_pixel_bus[(ARRAY_SIZE-gi)*WIDTH-1 -: WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_conv_kernel_array_acc.sv
// Directed self-checking bench for conv_kernel_array_acc (6 lanes, 3x3, Q16.16).
module tb_conv_kernel_array_acc;

    localparam int W  = 32;
    localparam int AS = 6;
    localparam int BW = AS * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [W-1:0]  i_bias = '0;
    logic          i_relu_en = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [BW-1:0] i_pixel_bus = '0;
    logic [W-1:0]  i_weight = '0;
    logic          o_valid;
    logic          i_out_ready = 1'b0;
    logic [BW-1:0] o_pixel_bus;
    logic          o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    conv_kernel_array_acc dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_bias      (i_bias),
        .i_relu_en   (i_relu_en),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_pixel_bus (i_pixel_bus),
        .i_weight    (i_weight),
        .o_valid     (o_valid),
        .i_out_ready (i_out_ready),
        .o_pixel_bus (o_pixel_bus),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-16s observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [BW-1:0] rep(input logic [W-1:0] v);
        return {AS{v}};
    endfunction

    task automatic start_job(input logic [W-1:0] bias, input logic relu, input string tag);
        i_start   = 1'b1;
        i_bias    = bias;
        i_relu_en = relu;
        tick();
        i_start = 1'b0;
        i_bias  = '0;
        check({tag, "_ready"}, BW'(o_ready), BW'(1));
    endtask

    task automatic feed(input logic [BW-1:0] pix, input logic [W-1:0] wgt, input int n);
        for (int t = 0; t < n; t++) begin
            i_valid     = 1'b1;
            i_pixel_bus = pix;
            i_weight    = wgt;
            tick();
        end
        i_valid = 1'b0;
    endtask

    // Called right after the edge that accepted the last tap.
    task automatic finish_job(input logic [BW-1:0] exp, input string tag);
        check({tag, "_round"}, BW'(o_valid), BW'(0));
        tick();
        check({tag, "_valid"}, BW'(o_valid), BW'(1));
        check({tag, "_bus"}, o_pixel_bus, exp);
        i_out_ready = 1'b1;
        tick();
        i_out_ready = 1'b0;
        check({tag, "_idle"}, BW'({o_busy, o_valid}), BW'(0));
    endtask

    localparam logic [W-1:0] ONE  = 32'h0001_0000;
    localparam logic [W-1:0] HALF = 32'h0000_8000;
    localparam logic [W-1:0] MAXP = 32'h7FFF_FFFF;
    localparam logic [W-1:0] MAXN = 32'h8000_0001;

    initial begin
        logic [15:0]   vpat;
        logic [BW-1:0] hold_bus;
        int            accepts;
        int            cyc;
        logic          will_accept;

        // Reset state
        tick();
        tick();
        check("rst_outputs", BW'({o_valid, o_ready, o_busy}), BW'(0));
        check("rst_bus", o_pixel_bus, '0);
        rst_n = 1'b1;
        tick();
        check("idle_ready", BW'(o_ready), BW'(0));

        // Ones window; i_valid high together with i_start must not count a tap
        i_valid     = 1'b1;
        i_pixel_bus = rep(ONE);
        i_weight    = ONE;
        start_job('0, 1'b0, "ones");
        check("ones_busy", BW'(o_busy), BW'(1));
        feed(rep(ONE), ONE, 9);
        finish_job(rep(32'h0009_0000), "ones");

        // Per-lane ramp, weight 0.5, bias -1.0, ReLU on (back-to-back start)
        start_job(32'hFFFF_0000, 1'b1, "ramp");
        feed({32'h0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 32'h0005_0000},
             HALF, 9);
        finish_job({32'h0, 32'h0003_8000, 32'h0008_0000, 32'h000C_8000, 32'h0011_0000, 32'h0015_8000},
                   "ramp");

        // Saturation high, low, low with ReLU
        start_job('0, 1'b0, "sat_hi");
        feed(rep(MAXP), MAXP, 9);
        finish_job(rep(32'h7FFF_FFFF), "sat_hi");
        start_job('0, 1'b0, "sat_lo");
        feed(rep(MAXP), MAXN, 9);
        finish_job(rep(32'h8000_0000), "sat_lo");
        start_job('0, 1'b1, "sat_relu");
        feed(rep(MAXP), MAXN, 9);
        finish_job(rep(32'h0), "sat_relu");

        // Stalled taps, stray start while busy, output backpressure
        start_job('0, 1'b0, "stall");
        vpat        = 16'b0110_1011_0011_0101;
        accepts     = 0;
        cyc         = 0;
        i_pixel_bus = rep(ONE);
        i_weight    = ONE;
        while (accepts < 9 && cyc < 100) begin
            i_valid     = vpat[cyc % 16];
            i_start     = (cyc == 3);
            i_bias      = (cyc == 3) ? 32'h7FFF_0000 : 32'h0;
            will_accept = i_valid && o_ready;
            tick();
            if (will_accept) accepts++;
            cyc++;
        end
        i_start = 1'b0;
        i_bias  = '0;
        check("stall_taps", BW'(accepts), BW'(9));
        i_valid = 1'b1;   // extra taps must be ignored from here on
        check("stall_round", BW'(o_valid), BW'(0));
        tick();
        hold_bus = rep(32'h0009_0000);
        for (int c = 0; c < 5; c++) begin
            i_start = (c == 2);
            i_bias  = (c == 2) ? 32'h1234_0000 : 32'h0;
            check("bp_valid", BW'(o_valid), BW'(1));
            check("bp_ready", BW'(o_ready), BW'(0));
            check("bp_bus", o_pixel_bus, hold_bus);
            tick();
        end
        i_start     = 1'b0;
        i_bias      = '0;
        i_valid     = 1'b0;
        check("bp_still", BW'(o_valid), BW'(1));
        i_out_ready = 1'b1;
        tick();
        i_out_ready = 1'b0;
        check("bp_idle", BW'(o_busy), BW'(0));

        // Reset mid-job after 4 taps, asynchronous effect
        start_job('0, 1'b0, "mid");
        feed(rep(ONE), ONE, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctl", BW'({o_valid, o_ready, o_busy}), BW'(0));
        check("mid_rst_bus", o_pixel_bus, '0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", BW'(o_busy), BW'(0));
        start_job('0, 1'b0, "post");
        feed(rep(ONE), ONE, 9);
        finish_job(rep(32'h0009_0000), "post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_kernel_array_acc.md
# conv_kernel_array_acc

Parametrised successor to the fixed six-lane convolution kernel row: ARRAY_SIZE multiply-accumulate lanes share one broadcast weight. Each lane accumulates a full KERNEL_SIZE×KERNEL_SIZE window, then adds bias, applies saturation and optional ReLU. Results are presented on a valid/ready output. Sits between the line-buffer/window feeder and the pooling stage of the conv layer.

## Interface
Parameters:
- WIDTH, 32, pixel/weight/bias/result width, signed fixed point
- FRAC_BITS, 16, fractional bits of all WIDTH-wide operands
- KERNEL_SIZE, 3, window edge; taps per job = KERNEL_SIZE²
- ARRAY_SIZE, 6, number of parallel lanes (≥1)
- ACC_WIDTH, 2*WIDTH+$clog2(KERNEL_SIZE²), accumulator width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  begin job; sampled only in IDLE
- i_bias  in  WIDTH  bias, latched on accepted i_start
- i_relu_en  in  1  ReLU enable, latched on accepted i_start
- i_valid  in  1  tap data valid
- o_ready  out  1  tap accepted when i_valid && o_ready
- i_pixel_bus  in  ARRAY_SIZE*WIDTH  lane k at bits [(ARRAY_SIZE-k)*WIDTH-1 : (ARRAY_SIZE-k-1)*WIDTH]
- i_weight  in  WIDTH  weight broadcast to all lanes
- o_valid  out  1  results valid
- i_out_ready  in  1  downstream accepts results
- o_pixel_bus  out  ARRAY_SIZE*WIDTH  results, same lane mapping
- o_busy  out  1  high in every state except IDLE

## Operation
- FSM: IDLE → ACCUM → ROUND → OUT → IDLE.
- IDLE: o_ready=0. i_start=1 clears all accumulators and tap counter, latches bias/relu, goes to ACCUM.
- ACCUM: o_ready=1. Each accepted tap: acc[k] += sext(pixel[k]*weight), full 2*WIDTH signed product. Tap counter increments. The accept of tap KERNEL_SIZE²-1 moves to ROUND. Cycles with i_valid=0 do not change state.
- ROUND (1 cycle): per lane, r = (acc >>> FRAC_BITS) + sext(bias). The shift is arithmetic, floor. r saturates to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. If relu latched and r<0, r=0. r is registered into o_pixel_bus. Go to OUT.
- OUT: o_valid=1; o_pixel_bus is held stable until i_out_ready=1, then IDLE.
- i_start outside IDLE is ignored.
- i_start with i_valid in the same cycle in IDLE: the tap is not accepted, because o_ready=0.
- Async reset: state IDLE, accumulators 0, tap counter 0, o_valid 0, o_ready 0, o_busy 0, o_pixel_bus 0, latched bias 0, relu 0. Reset mid-job aborts the job with no output.

## Timing
- Accepted i_start at edge N: o_ready=1 from N.
- Last tap accepted at edge M: o_valid=1 after edge M+1.
- Minimum job length is 1 + KERNEL_SIZE² + 2 cycles with no stalls.
- Back-to-back jobs: i_start is accepted earliest in the cycle after the OUT handshake.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.

## Structure
- Shared package conv_pkg holds:
  - state enum {IDLE, ACCUM, ROUND, OUT}
  - function for the ACC_WIDTH default
  - saturation helper function
- Sub-module conv_mac_lane (one per lane, generate loop) contains:
  - accumulator
  - product
  - round/bias/saturate/ReLU register
  - controls: clr, acc_en, round_en
- The top holds the FSM, tap counter, bias/relu latches and bus slicing.

## Test plan
WIDTH=32, FRAC_BITS=16, KERNEL_SIZE=3, ARRAY_SIZE=6. 1.0 = 0x00010000.

- Ones window: all pixels 1.0, weight 1.0, bias 0, relu off, 9 taps back-to-back → every lane 0x00090000. o_valid rises 2 cycles after the 9th accept.
- Per-lane ramp: pixel[k]=k·1.0, weight 0.5, bias −1.0, relu on → lane0=0, lane1=0x00038000, lane5=0x00158000.
- Saturation: pixel 0x7FFFFFFF, weight 0x7FFFFFFF, bias 0 → all lanes 0x7FFFFFFF. Negating the weight with relu off → 0x80000000; with relu on → 0.
- Stalls and backpressure:
  - Setup: i_valid toggles randomly; i_out_ready low for 5 cycles; i_start pulsed while busy.
  - Required: exactly 9 taps counted; o_pixel_bus stable while waiting; o_ready=0 in OUT; stray i_start ignored.
- Reset mid-job: rst_n low after 4 taps → all outputs 0 asynchronously. The following full ones job still yields 0x00090000.
